io_int_gen: RTL and testbench

Input-change interrupt generator for the 16-pin I2C port expander. Sits between the raw PORT0/PORT1 pins and the I2C slave register file. It synchronises and debounces the pin levels and presents stable values for the slave's input registers 0 and 1. It also drives the active-low open-drain INT_N line whenever an input-configured pin differs from the value the host last read.

---
 rtl/io_int_gen.sv | 130 +++++++++++++
 tb/tb_io_int_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_int_gen.sv
// io_int_gen: input-change interrupt generator for a 16-pin I2C port expander.
// Synchronises and debounces {port1_in, port0_in}. Presents stable levels for
// input registers 0/1. Pulls the open-drain INT_N low while any input pin
// differs from the level the host last read.
//
// Build option: define IO_INT_LATCH_EN for sticky change flags. Without it,
// flags are transparent: a pin returning to its snapshot level clears its flag.
//
// rd_strobe0/rd_strobe1 are single-cycle pulses with no back-pressure. A strobe
// means the slave has just sampled in0_stable/in1_stable. The snapshot for that
// port then takes the pre-edge stable value, which is exactly what the host
// receives.
module io_int_gen #(
  parameter int DEB_CYCLES = 50
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  port0_in,
  input  logic [7:0]  port1_in,
  input  logic [7:0]  cfg0,
  input  logic [7:0]  cfg1,
  input  logic        rd_strobe0,
  input  logic        rd_strobe1,
  output logic [7:0]  in0_stable,
  output logic [7:0]  in1_stable,
  output logic [15:0] chg_flags,
  output logic        INT_N,
  output logic        dbg_state
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [15:0]   s1, s2, cand, stable_q;
  logic [CW-1:0] cnt;
  logic          stable_load;

  state_t        state_q, state_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   flags_d;
  logic [15:0]   cfg_q;
  logic [15:0]   cfg_in, cfg_rise, strobe_mask, reload_mask, raw_chg;

  // Two-flop synchroniser feeding a shared-window debouncer.
  always_ff @(posedge clk) begin
    if (RST) begin
      s1       <= '0;
      s2       <= '0;
      cand     <= '0;
      cnt      <= '0;
      stable_q <= '0;
    end else begin
      s1 <= {port1_in, port0_in};
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end else begin
        stable_q <= cand;
      end
    end
  end

  assign stable_load = (s2 == cand) && (cnt == CNT_MAX);

  assign cfg_in      = {cfg1, cfg0};
  assign cfg_rise    = cfg_in & ~cfg_q;
  assign strobe_mask = {{8{rd_strobe1}}, {8{rd_strobe0}}};
  assign reload_mask = strobe_mask | cfg_rise;
  // A pin that has just switched to input is masked for one edge while its
  // snapshot is reloaded, so a direction change alone never interrupts.
  assign raw_chg     = cfg_in & cfg_q & (stable_q ^ snap_q);

  // State, snapshot, direction history and flag registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= ST_INIT;
      snap_q    <= '0;
      chg_flags <= '0;
      cfg_q     <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      chg_flags <= flags_d;
      cfg_q     <= cfg_in;
    end
  end

  // Next state: INIT waits for the first debounced load and snapshots it, so
  // power-up levels are never reported; RUN tracks reads and changes.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    flags_d = chg_flags;
    case (state_q)
      ST_INIT: begin
        flags_d = '0;
        if (stable_load) begin
          state_d = ST_RUN;
          snap_d  = cand;
        end
      end
      ST_RUN: begin
        snap_d = (snap_q & ~reload_mask) | (stable_q & reload_mask);
`ifdef IO_INT_LATCH_EN
        flags_d = ((chg_flags | raw_chg) & ~strobe_mask) & cfg_in;
`else
        flags_d = raw_chg;
`endif
      end
      default: begin
        state_d = ST_INIT;
        flags_d = '0;
      end
    endcase
  end

  assign in0_stable = stable_q[7:0];
  assign in1_stable = stable_q[15:8];
  assign dbg_state  = (state_q == ST_RUN);
  assign INT_N      = (|chg_flags) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_io_int_gen.sv
// Testbench for io_int_gen with DEB_CYCLES = 4.
module tb_io_int_gen;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port0_in, port1_in, cfg0, cfg1;
  logic        rd_strobe0, rd_strobe1;
  logic [7:0]  in0_stable, in1_stable;
  logic [15:0] chg_flags;
  logic        dbg_state;
  wire         int_n;

  pullup (int_n);

  int n_checks = 0;
  int n_errors = 0;

  io_int_gen #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .RST        (rst),
    .port0_in   (port0_in),
    .port1_in   (port1_in),
    .cfg0       (cfg0),
    .cfg1       (cfg1),
    .rd_strobe0 (rd_strobe0),
    .rd_strobe1 (rd_strobe1),
    .in0_stable (in0_stable),
    .in1_stable (in1_stable),
    .chg_flags  (chg_flags),
    .INT_N      (int_n),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Stable follows the synchronised pin history: a value is accepted once
  // DEB+1 consecutive synchronised samples agree and at least DEB edges have
  // passed since reset. Flags follow the per-pin rules from the datasheet.
  logic [15:0] m_hist [0:6];
  logic [15:0] m_stable, m_snap, m_flags, m_cfgq;
  logic        m_run;
  int          m_since;

  always @(posedge clk) begin : model
    logic [15:0] h [0:6];
    logic [15:0] pins, cfg, stb, nsnap, nflags, nstable;
    logic        win_ok, nrun;
    pins = {port1_in, port0_in};
    cfg  = {cfg1, cfg0};
    stb  = {{8{rd_strobe1}}, {8{rd_strobe0}}};
    if (rst) begin
      for (int i = 0; i < 7; i++) m_hist[i] <= '0;
      m_since  <= 0;
      m_stable <= '0;
      m_snap   <= '0;
      m_flags  <= '0;
      m_cfgq   <= 16'hFFFF;
      m_run    <= 1'b0;
    end else begin
      h[0] = pins;
      for (int i = 1; i < 7; i++) h[i] = m_hist[i-1];
      win_ok = ((m_since + 1) >= DEB);
      for (int i = 3; i <= 6; i++) if (h[i] != h[2]) win_ok = 1'b0;
      nstable = win_ok ? h[2] : m_stable;
      nsnap   = m_snap;
      nflags  = m_flags;
      nrun    = m_run;
      if (!m_run) begin
        if (win_ok) begin
          nrun  = 1'b1;
          nsnap = h[2];
        end
      end else begin
        for (int i = 0; i < 16; i++) begin
          if (stb[i] || (cfg[i] && !m_cfgq[i])) nsnap[i] = m_stable[i];
`ifdef IO_INT_LATCH_EN
          if (stb[i] || !cfg[i]) nflags[i] = 1'b0;
          else if (m_cfgq[i] && (m_stable[i] != m_snap[i])) nflags[i] = 1'b1;
`else
          nflags[i] = cfg[i] && m_cfgq[i] && (m_stable[i] != m_snap[i]);
`endif
        end
      end
      for (int i = 0; i < 7; i++) m_hist[i] <= h[i];
      m_since  <= (m_since < DEB) ? m_since + 1 : m_since;
      m_stable <= nstable;
      m_snap   <= nsnap;
      m_flags  <= nflags;
      m_cfgq   <= cfg;
      m_run    <= nrun;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input logic [15:0] pins);
    {port1_in, port0_in} = pins;
    rd_strobe0 = 1'b0;
    rd_strobe1 = 1'b0;
    repeat (12) tick();
    rd_strobe0 = 1'b1;
    rd_strobe1 = 1'b1;
    tick();
    rd_strobe0 = 1'b0;
    rd_strobe1 = 1'b0;
    repeat (2) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    {port1_in, port0_in} = 16'hA55A;
    cfg0 = 8'hFF;
    cfg1 = 8'hFF;
    rd_strobe0 = 1'b0;
    rd_strobe1 = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({in1_stable, in0_stable, chg_flags} !== 32'h0 || int_n !== 1'b1 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: stable=%h flags=%h int_n=%b state=%b, want 0/0/1/0",
               {in1_stable, in0_stable}, chg_flags, int_n, dbg_state);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (int_n !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_int_quiet: edge %0d int_n=%b want 1", e, int_n);
      end
      if (e == 6) begin
        n_checks++;
        if ({in1_stable, in0_stable} !== 16'h0000 || dbg_state !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_early: stable=%h state=%b want 0000/0", {in1_stable, in0_stable}, dbg_state);
        end
      end
      if (e == 7) begin
        n_checks++;
        if (in0_stable !== 8'h5A || in1_stable !== 8'hA5 || dbg_state !== 1'b1) begin
          n_errors++;
          $display("FAIL reset_load: in0=%h in1=%h state=%b want 5a/a5/1", in0_stable, in1_stable, dbg_state);
        end
      end
    end
  endtask

  task automatic test_pin_change();
    settle(16'hA552);
    port0_in[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) begin
        n_checks++;
        if (in0_stable !== 8'h5A) begin
          n_errors++;
          $display("FAIL change_stable: in0=%h want 5a", in0_stable);
        end
      end
      if (e < 8) begin
        n_checks++;
        if (chg_flags !== 16'h0000) begin
          n_errors++;
          $display("FAIL change_early: edge %0d flags=%h want 0000", e, chg_flags);
        end
      end else begin
        n_checks++;
        if (chg_flags !== 16'h0008 || int_n !== 1'b0) begin
          n_errors++;
          $display("FAIL change_flag: flags=%h int_n=%b want 0008/0", chg_flags, int_n);
        end
      end
    end
    rd_strobe0 = 1'b1;
    tick();
    rd_strobe0 = 1'b0;
    n_checks++;
`ifdef IO_INT_LATCH_EN
    if (chg_flags !== 16'h0000) begin
      n_errors++;
      $display("FAIL strobe_edge: flags=%h want 0000", chg_flags);
    end
`else
    if (chg_flags !== 16'h0008) begin
      n_errors++;
      $display("FAIL strobe_edge: flags=%h want 0008", chg_flags);
    end
`endif
    tick();
    n_checks++;
    if (chg_flags !== 16'h0000 || int_n !== 1'b1) begin
      n_errors++;
      $display("FAIL strobe_clear: flags=%h int_n=%b want 0000/1", chg_flags, int_n);
    end
  endtask

  task automatic test_glitch();
    settle(16'hA55A);
    port1_in[0] = 1'b0;
    repeat (3) tick();
    port1_in[0] = 1'b1;
    for (int e = 0; e < 15; e++) begin
      tick();
      n_checks++;
      if (int_n !== 1'b1 || in1_stable !== 8'hA5) begin
        n_errors++;
        $display("FAIL glitch: cycle %0d int_n=%b in1=%h want 1/a5", e, int_n, in1_stable);
      end
    end
  endtask

  task automatic test_output_pin();
    cfg0 = 8'hFE;
    tick();
    port0_in[0] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      n_checks++;
      if (chg_flags !== 16'h0000) begin
        n_errors++;
        $display("FAIL output_pin: cycle %0d flags=%h want 0000", e, chg_flags);
      end
    end
    n_checks++;
    if (in0_stable !== 8'h5B) begin
      n_errors++;
      $display("FAIL output_pin_level: in0=%h want 5b", in0_stable);
    end
    cfg0 = 8'hFF;
    for (int e = 0; e < 6; e++) begin
      tick();
      n_checks++;
      if (chg_flags !== 16'h0000 || int_n !== 1'b1) begin
        n_errors++;
        $display("FAIL cfg_to_input: cycle %0d flags=%h int_n=%b want 0000/1", e, chg_flags, int_n);
      end
    end
  endtask

  task automatic test_restore();
    int waited;
    port0_in[1] = 1'b0;
    waited = 0;
    while (int_n !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (int_n !== 1'b0) begin
      n_errors++;
      $display("FAIL restore_assert: int_n=%b after %0d cycles want 0", int_n, waited);
    end
    port0_in[1] = 1'b1;
`ifdef IO_INT_LATCH_EN
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (int_n !== 1'b0 || chg_flags !== 16'h0002) begin
        n_errors++;
        $display("FAIL restore_sticky: edge %0d int_n=%b flags=%h want 0/0002", e, int_n, chg_flags);
      end
    end
    rd_strobe0 = 1'b1;
    tick();
    rd_strobe0 = 1'b0;
    n_checks++;
    if (int_n !== 1'b1) begin
      n_errors++;
      $display("FAIL restore_read: int_n=%b want 1", int_n);
    end
`else
    for (int e = 1; e <= DEB + 4; e++) begin
      tick();
      n_checks++;
      if (e < DEB + 4 && int_n !== 1'b0) begin
        n_errors++;
        $display("FAIL restore_hold: edge %0d int_n=%b want 0", e, int_n);
      end else if (e == DEB + 4 && int_n !== 1'b1) begin
        n_errors++;
        $display("FAIL restore_release: edge %0d int_n=%b want 1", e, int_n);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int waited;
    port0_in[5] = 1'b1;
    waited = 0;
    while (int_n !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (int_n !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_assert: int_n=%b want 0", int_n);
    end
    port1_in[2] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({in1_stable, in0_stable, chg_flags} !== 32'h0 || int_n !== 1'b1 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_values: stable=%h flags=%h int_n=%b state=%b want 0/0/1/0",
               {in1_stable, in0_stable}, chg_flags, int_n, dbg_state);
    end
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      n_checks++;
      if (int_n !== 1'b1) begin
        n_errors++;
        $display("FAIL midrst_quiet: cycle %0d int_n=%b want 1", e, int_n);
      end
    end
    n_checks++;
    if (dbg_state !== 1'b1 || in0_stable !== 8'h7B || in1_stable !== 8'hA1) begin
      n_errors++;
      $display("FAIL midrst_reinit: state=%b in0=%h in1=%h want 1/7b/a1", dbg_state, in0_stable, in1_stable);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        int b;
        b = $urandom_range(0, 15);
        if (b < 8) port0_in[b] = ~port0_in[b];
        else       port1_in[b-8] = ~port1_in[b-8];
      end
      if ($urandom_range(0, 39) == 0) begin
        int b;
        b = $urandom_range(0, 15);
        if (b < 8) cfg0[b] = ~cfg0[b];
        else       cfg1[b-8] = ~cfg1[b-8];
      end
      rd_strobe0 = ($urandom_range(0, 4) == 0);
      rd_strobe1 = ($urandom_range(0, 4) == 0);
      tick();
      n_checks++;
      if ({in1_stable, in0_stable} !== m_stable) begin
        n_errors++;
        $display("FAIL rand_stable: cycle %0d got %h want %h", c, {in1_stable, in0_stable}, m_stable);
      end
      n_checks++;
      if (chg_flags !== m_flags) begin
        n_errors++;
        $display("FAIL rand_flags: cycle %0d got %h want %h", c, chg_flags, m_flags);
      end
      n_checks++;
      if (int_n !== ((m_flags != 16'h0) ? 1'b0 : 1'b1)) begin
        n_errors++;
        $display("FAIL rand_int_n: cycle %0d got %b want %b", c, int_n, (m_flags == 16'h0));
      end
      n_checks++;
      if (dbg_state !== m_run) begin
        n_errors++;
        $display("FAIL rand_state: cycle %0d got %b want %b", c, dbg_state, m_run);
      end
    end
    rd_strobe0 = 1'b0;
    rd_strobe1 = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pin_change();
    test_glitch();
    test_output_pin();
    test_restore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
